mode_router: RTL and testbench

//   Parametrised successor to the two-way controller/maintenance output steering in the chip dispenser.

---
 rtl/mode_router_pkg.sv | 15 +
 rtl/mode_router_guard_timer.sv | 39 +++
 rtl/mode_router.sv | 120 ++++++++++++
 tb/tb_mode_router.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mode_router_pkg.sv
// Shared definitions for the chip-dispenser mode router: state encoding and
// the default idle codes of the controller and maintenance consumers.
package mode_router_pkg;

  typedef enum logic {
    ST_ROUTE = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam int          DEF_WIDTH  = 7;
  localparam logic [6:0]  CTRL_IDLE  = 7'b1101110;
  localparam logic [6:0]  MAINT_IDLE = 7'b0111111;
  localparam logic [13:0] DEF_IDLE_CODES = {MAINT_IDLE, CTRL_IDLE};

endpackage

// File: rtl/mode_router_guard_timer.sv
// Loadable saturating down-counter that times the all-idle guard interval
// between two routed channels; done is high while the count is zero.
module guard_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mode_router.sv
// Steers the mbed command word to one of CHANNELS consumers, holding every
// other channel at its idle code and blanking all channels during a change.
module mode_router
  import mode_router_pkg::*;
#(
  parameter int                          WIDTH        = DEF_WIDTH,
  parameter int                          CHANNELS     = 2,
  parameter int                          SEL_W        = 1,
  parameter int                          GUARD_CYCLES = 4,
  parameter logic [CHANNELS*WIDTH-1:0]   IDLE_CODES   = DEF_IDLE_CODES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          select,
  input  logic [WIDTH-1:0]          mbed_input,
  output logic [CHANNELS*WIDTH-1:0] chan_out,
  output logic [SEL_W-1:0]          active_chan,
  output logic                      switching,
  output logic                      sel_error
);

  localparam int                CNT_W      = $clog2(GUARD_CYCLES) + 1;
  localparam logic [SEL_W:0]    CHAN_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          target_q, target_d;
  logic [SEL_W-1:0]          active_q, active_d;
  logic [CHANNELS*WIDTH-1:0] chan_q, chan_d;
  logic                      switching_q, switching_d;
  logic                      sel_error_q, sel_error_d;
  logic                      sel_valid;
  logic                      timer_load;
  logic                      timer_done;

  assign sel_valid = ({1'b0, select} < CHAN_LIM);

  guard_timer #(
    .CNT_W (CNT_W)
  ) u_guard (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (GUARD_LOAD),
    .done     (timer_done)
  );

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ROUTE;
      target_q    <= {SEL_W{1'b0}};
      active_q    <= {SEL_W{1'b0}};
      chan_q      <= IDLE_CODES;
      switching_q <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      active_q    <= active_d;
      chan_q      <= chan_d;
      switching_q <= switching_d;
      sel_error_q <= sel_error_d;
    end
  end

  // next state; an invalid select never disturbs routing or the guard count
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    active_d   = active_q;
    timer_load = 1'b0;
    case (state_q)
      ST_ROUTE: begin
        if (sel_valid && (select != active_q)) begin
          state_d    = ST_DRAIN;
          target_d   = select;
          timer_load = 1'b1;
        end else begin
          state_d    = ST_ROUTE;
        end
      end
      ST_DRAIN: begin
        // a new request restarts the guard, even a return to the old channel
        if (sel_valid && (select != target_q)) begin
          target_d   = select;
          timer_load = 1'b1;
        end else if (!timer_done) begin
          state_d    = ST_DRAIN;
        end else begin
          state_d    = ST_ROUTE;
          active_d   = target_q;
        end
      end
      default: begin
        state_d  = ST_ROUTE;
        target_d = {SEL_W{1'b0}};
        active_d = {SEL_W{1'b0}};
      end
    endcase
  end

  // output next-values follow the state being entered at this edge
  always_comb begin
    switching_d = (state_d == ST_DRAIN);
    sel_error_d = ~sel_valid;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chan_d[i*WIDTH +: WIDTH] =
      ((state_d == ST_ROUTE) && (active_d == SEL_W'(i))) ? mbed_input
                                                          : IDLE_CODES[i*WIDTH +: WIDTH];
  end

  assign chan_out    = chan_q;
  assign active_chan = active_q;
  assign switching   = switching_q;
  assign sel_error   = sel_error_q;

endmodule

// File: tb/tb_mode_router.sv
// Bench for mode_router: three configurations, each with directed literal
// checks followed by random traffic compared every cycle against a model.
module tb_mode_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done_a [3];

  function automatic logic [20:0] idle_of(input int g);
    case (g)
      1:       return {7'h55, 7'b0111111, 7'b1101110};
      2:       return {7'h00, 7'h3c, 7'h41};
      default: return {7'h00, 7'b0111111, 7'b1101110};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CH = (g == 1) ? 3 : 2;
    localparam int SW = (g == 1) ? 2 : 1;
    localparam int GC = (g == 2) ? 1 : 4;
    localparam logic [20:0]     IDLE_ALL = idle_of(g);
    localparam logic [CH*7-1:0] IDLE     = IDLE_ALL[CH*7-1:0];

    logic            rst;
    logic [SW-1:0]   sel;
    logic [6:0]      mbed;
    logic [CH*7-1:0] chan;
    logic [SW-1:0]   act;
    logic            sw, err;

    mode_router #(
      .WIDTH(7), .CHANNELS(CH), .SEL_W(SW), .GUARD_CYCLES(GC), .IDLE_CODES(IDLE)
    ) dut (
      .clk(clk), .reset(rst), .select(sel), .mbed_input(mbed),
      .chan_out(chan), .active_chan(act), .switching(sw), .sel_error(err)
    );

    // Model: p = pending channel (-1 none), r = idle edges still owed.
    int              m_a = 0, m_p = -1, m_rem = 0;
    logic [CH*7-1:0] m_vec;
    bit              m_sw, m_err, m_ok = 1'b0;

    always @(posedge clk) begin : mdl
      int a, p, r, s;
      logic [CH*7-1:0] v;
      bit sw1, er1;
      a = m_a; p = m_p; r = m_rem; s = int'(sel);
      v = IDLE; sw1 = 1'b0; er1 = 1'b0;
      if (rst === 1'b1) begin
        a = 0; p = -1; r = 0;
      end else begin
        er1 = (s >= CH);
        if (s < CH && s != ((p < 0) ? a : p)) begin
          p = s; r = GC;
        end
        if (p >= 0 && r > 0) begin
          r = r - 1; sw1 = 1'b1;
        end else begin
          if (p >= 0) begin a = p; p = -1; end
          v[a*7 +: 7] = mbed;
        end
      end
      m_a   <= a;
      m_p   <= p;
      m_rem <= r;
      m_vec <= v;
      m_sw  <= sw1;
      m_err <= er1;
      m_ok  <= m_ok | (rst === 1'b1);
    end

    always @(negedge clk) begin
      if (m_ok) begin
        chk($sformatf("c%0d model chan_out", g), 64'(chan), 64'(m_vec));
        chk($sformatf("c%0d model active_chan", g), 64'(act), 64'(m_a));
        chk($sformatf("c%0d model switching", g), 64'(sw), 64'(m_sw));
        chk($sformatf("c%0d model sel_error", g), 64'(err), 64'(m_err));
      end
    end

    function automatic logic [CH*7-1:0] routed(input int c, input logic [6:0] w);
      logic [CH*7-1:0] v;
      v = IDLE;
      v[c*7 +: 7] = w;
      return v;
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    initial begin : stim
      int hold;
      int nrev;
      bit exp_e;
      hold = 0;
      nrev = (GC > 1) ? 2 : 1;
      exp_e = ((2**SW - 1) >= CH);

      // reset state, then first routed word
      rst = 1'b1; sel = '0; mbed = 7'h15;
      step(); step();
      chk($sformatf("c%0d reset chan_out", g), 64'(chan), 64'(IDLE));
      chk($sformatf("c%0d reset active", g), 64'(act), 64'd0);
      chk($sformatf("c%0d reset switching", g), 64'(sw), 64'd0);
      rst = 1'b0;
      step();
      chk($sformatf("c%0d first route", g), 64'(chan), 64'(routed(0, 7'h15)));

      // change 0 -> 1: GC idle edges, then channel 1 routed
      sel = SW'(1); mbed = 7'h2a;
      for (int k = 0; k < GC; k++) begin
        step();
        chk($sformatf("c%0d guard%0d switching", g, k), 64'(sw), 64'd1);
        chk($sformatf("c%0d guard%0d chan_out", g, k), 64'(chan), 64'(IDLE));
      end
      step();
      chk($sformatf("c%0d switch active", g), 64'(act), 64'd1);
      chk($sformatf("c%0d switch chan_out", g), 64'(chan), 64'(routed(1, 7'h2a)));
      chk($sformatf("c%0d switch done", g), 64'(sw), 64'd0);

      // request 0, then revert to 1: guard restarts for a full interval
      sel = SW'(0); mbed = 7'h33;
      for (int k = 0; k < nrev; k++) begin
        step();
        chk($sformatf("c%0d pre-revert idle%0d", g, k), 64'(chan), 64'(IDLE));
      end
      sel = SW'(1);
      for (int k = 0; k < GC; k++) begin
        step();
        chk($sformatf("c%0d restart idle%0d", g, k), 64'(chan), 64'(IDLE));
        chk($sformatf("c%0d restart sw%0d", g, k), 64'(sw), 64'd1);
      end
      step();
      chk($sformatf("c%0d restart route", g), 64'(chan), 64'(routed(1, 7'h33)));

      // top select code held: error pulses only where it is out of range
      sel = SW'(2**SW - 1); mbed = 7'h0f;
      for (int k = 0; k < 3; k++) begin
        step();
        chk($sformatf("c%0d hold sel_error%0d", g, k), 64'(err), 64'(exp_e));
        chk($sformatf("c%0d hold switching%0d", g, k), 64'(sw), 64'd0);
        chk($sformatf("c%0d hold chan_out%0d", g, k), 64'(chan), 64'(routed(1, 7'h0f)));
      end
      sel = SW'(1);
      step();
      chk($sformatf("c%0d error clears", g), 64'(err), 64'd0);

      // reset during the guard interval discards the pending change
      sel = SW'(0);
      step();
      rst = 1'b1;
      step();
      chk($sformatf("c%0d drain reset chan_out", g), 64'(chan), 64'(IDLE));
      chk($sformatf("c%0d drain reset active", g), 64'(act), 64'd0);
      chk($sformatf("c%0d drain reset sw", g), 64'(sw), 64'd0);
      rst = 1'b0; mbed = 7'h4c;
      step();
      chk($sformatf("c%0d post reset route", g), 64'(chan), 64'(routed(0, 7'h4c)));

      // random traffic with held selects and occasional resets
      for (int n = 0; n < 500; n++) begin
        if (hold == 0) begin
          sel  = SW'($urandom_range(0, 2**SW - 1));
          hold = $urandom_range(1, GC + 4);
        end
        hold = hold - 1;
        mbed = 7'($urandom);
        rst  = ($urandom_range(0, 49) == 0);
        step();
      end
      rst = 1'b0;
      step();
      done_a[g] = 1'b1;
    end
  end

  initial begin : main
    for (int c = 0; c < 20000; c++) begin
      if (done_a[0] && done_a[1] && done_a[2]) break;
      @(posedge clk);
    end
    if (!(done_a[0] && done_a[1] && done_a[2])) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: stimulus done %0b%0b%0b expected 111", done_a[2], done_a[1], done_a[0]);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
